// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte stream to instruction memory loader, holds CPU in reset until loaded
// Optional trailing checksum verification enabled by LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int Width       = 32,
  parameter int DEPTH_WORDS = 32,
  parameter int LEN_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [Width-1:0] wr_addr,
  output logic [Width-1:0] wr_data,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DONE, ERR} state_t;
`endif

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_WORDS);

  state_t           state, state_nxt;
  logic [1:0]       byte_cnt;
  logic [23:0]      part;
  logic             fin;
  logic [LEN_W-1:0] target;
`ifdef LOADER_CHECKSUM_EN
  logic [Width-1:0] sum;
`endif

  logic             accept, last_byte, last_word, start_ok, idle_like;
  logic [Width-1:0] word;

  assign accept    = byte_valid & byte_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign last_word = (words_loaded == target - 1'b1);
  assign start_ok  = (num_words != '0) && (num_words <= DEPTH_L);
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  assign word      = Width'({byte_data, part});

  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);
`ifdef LOADER_CHECKSUM_EN
  assign busy     = (state == LOAD) || (state == CHECK);
`else
  assign busy     = (state == LOAD);
`endif

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = start_ok ? LOAD : ERR;
      end
      LOAD: begin
        // fin marks the write cycle of the final word; no more data bytes belong to this load
        byte_ready = ~fin;
`ifdef LOADER_CHECKSUM_EN
        if (fin) state_nxt = CHECK;
`else
        if (fin) state_nxt = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (last_byte) state_nxt = (word == sum) ? DONE : ERR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      part         <= '0;
      fin          <= 1'b0;
      target       <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      state <= state_nxt;
      wr_en <= 1'b0;
      if (idle_like && start && start_ok) begin
        byte_cnt     <= 2'd0;
        part         <= '0;
        fin          <= 1'b0;
        target       <= num_words;
        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum          <= '0;
`endif
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    part[7:0]   <= byte_data;
          2'd1:    part[15:8]  <= byte_data;
          2'd2:    part[23:16] <= byte_data;
          default: ;
        endcase
      end
      if ((state == LOAD) && last_byte) begin
        wr_en        <= 1'b1;
        wr_addr      <= Width'({words_loaded, 2'b00});
        wr_data      <= word;
        words_loaded <= words_loaded + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum          <= sum + word;
`endif
        if (last_word) fin <= 1'b1;
      end
    end
  end

endmodule
